// File: rtl/sqrt_issue_seq.sv
// sqrt_issue_seq: issues a vector of fp16 operands one at a time to a sqrt unit and gathers the results
module sqrt_issue_seq #(
  parameter int LANES   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   start,
  input  logic [LANES-1:0][15:0] vec_in,
  input  logic                   sq_ready,
  input  logic                   sq_valid_out,
  input  logic [15:0]            sq_output_val,
  output logic [15:0]            sq_input_val,
  output logic                   sq_valid_in,
  output logic [LANES-1:0][15:0] vec_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int IW = $clog2(LANES);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t                 r_state, w_next;
  logic [LANES-1:0][15:0] r_buf;
  logic [IW-1:0]          r_idx;
  logic [TW-1:0]          r_wd;
  logic                   w_last, w_tmo;
  assign w_last = r_idx == IW'(LANES - 1);
  assign w_tmo  = r_wd == TW'(TIMEOUT - 1);
  assign busy   = r_state != IDLE;
  assign done   = r_state == DONE;
  // next state: a lane finishes on a response or on watchdog expiry
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? ISSUE : IDLE;
      ISSUE:   w_next = sq_ready ? WAIT : ISSUE;
      WAIT:    w_next = (sq_valid_out || w_tmo) ? (w_last ? DONE : ISSUE) : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // state register, operand snapshot, request issue and result capture
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_buf        <= '0;
      r_idx        <= '0;
      r_wd         <= '0;
      sq_input_val <= '0;
      sq_valid_in  <= 1'b0;
      vec_out      <= '0;
      err          <= 1'b0;
    end else begin
      r_state     <= w_next;
      sq_valid_in <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_buf <= vec_in;
          r_idx <= '0;
          err   <= 1'b0;
        end
        ISSUE: if (sq_ready) begin
          sq_input_val <= r_buf[r_idx];
          sq_valid_in  <= 1'b1;
          r_wd         <= '0;
        end
        WAIT: if (sq_valid_out || w_tmo) begin
          vec_out[r_idx] <= sq_valid_out ? sq_output_val : 16'h7E00;
          err            <= err | ~sq_valid_out;
          r_idx          <= w_last ? r_idx : r_idx + 1'b1;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_issue_seq.sv
// tb_sqrt_issue_seq: directed checks of the sqrt issue sequencer against a latency-3 responder model
module tb_sqrt_issue_seq;
  localparam int LANES = 16, TIMEOUT = 64, L = 3;
  typedef logic [LANES-1:0][15:0] vec_t;
  logic        CLK = 1'b0, nRST = 1'b0, start = 1'b0, sq_ready = 1'b1, sq_valid_out = 1'b0;
  logic [15:0] sq_output_val = '0, sq_input_val, op = '0;
  logic        sq_valid_in, busy, done, err;
  vec_t        vec_in = '0, vec_out, v_basic, v_alt;
  int          checks = 0, failures = 0, rem = 0, lane_cnt = 0;

  always #5 CLK = ~CLK;

  sqrt_issue_seq #(.LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .vec_in(vec_in),
    .sq_ready(sq_ready), .sq_valid_out(sq_valid_out), .sq_output_val(sq_output_val),
    .sq_input_val(sq_input_val), .sq_valid_in(sq_valid_in), .vec_out(vec_out),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] f(input logic [15:0] x);
    return x == 16'h3C00 ? 16'h3C00 : x == 16'h4400 ? 16'h4000 :
           x == 16'h4C00 ? 16'h4400 : x == 16'h0000 ? 16'h0000 : 16'hBAD0;
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_vec_zero"}, 32'(vec_out == '0), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_vin"}, 32'(sq_valid_in), 0);
    check({tag, "_ival"}, 32'(sq_input_val), 0);
  endtask

  task automatic run(input vec_t v, input int stall_at, input int stall_len, input int spur_at,
                     input int silent, input int bs_at, input int abort_at, input int want_done);
    int   n = 0, done_n = 0, dones = 0, pulses = 0, dbl = 0, stall_bad = 0, op_bad = 0;
    logic prev = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    vec_in = v;
    rem = 0;
    lane_cnt = 0;
    @(posedge CLK);
    while (n < 400 && (done_n == 0 || n < done_n + 10)) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("err_clr_on_start", 32'(err), 0);
        check("busy_after_start", 32'(busy), 1);
      end
      if (n == abort_at) begin
        nRST = 1'b0;
        #1;
        reset_checks("abort");
        @(negedge CLK);
        nRST = 1'b1;
        rem = 0;
        sq_valid_out = 1'b0;
        return;
      end
      sq_valid_out = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          sq_valid_out = 1'b1;
          sq_output_val = f(op);
        end
      end
      if (sq_valid_in) begin
        if (lane_cnt >= LANES || sq_input_val !== v[lane_cnt]) op_bad++;
        if (lane_cnt != silent) begin
          rem = L;
          op = sq_input_val;
        end
        lane_cnt++;
        pulses++;
        if (prev) dbl++;
      end
      prev = sq_valid_in;
      if (n == spur_at) begin
        sq_valid_out = 1'b1;
        sq_output_val = 16'hDEAD;
      end
      if (n == stall_at) sq_ready = 1'b0;
      if (n == stall_at + stall_len) sq_ready = 1'b1;
      if (n >= stall_at && n <= stall_at + stall_len && sq_valid_in) stall_bad++;
      if (n == bs_at) begin
        start = 1'b1;
        vec_in = v_alt;
      end
      if (n == bs_at + 1) start = 1'b0;
      if (done) begin
        dones++;
        if (done_n == 0) done_n = n;
      end
      if (done_n != 0 && n == done_n + 1) check("busy_fall", 32'(busy), 0);
    end
    check("done_cycle", 32'(done_n), 32'(want_done));
    check("done_count", 32'(dones), 1);
    check("vin_pulses", 32'(pulses), LANES);
    check("vin_one_cycle", 32'(dbl), 0);
    check("vin_in_stall", 32'(stall_bad), 0);
    check("operand_order", 32'(op_bad), 0);
    check("err_final", 32'(err), 32'(silent >= 0));
    for (int i = 0; i < LANES; i++)
      check($sformatf("vec_out[%0d]", i), 32'(vec_out[i]), 32'(i == silent ? 16'h7E00 : f(v[i])));
  endtask

  initial begin
    v_basic = '0;
    v_basic[0] = 16'h3C00;
    v_basic[1] = 16'h4400;
    v_basic[2] = 16'h4C00;
    for (int i = 0; i < LANES; i++) v_alt[i] = 16'h4400;
    repeat (2) @(negedge CLK);
    reset_checks("reset");
    nRST = 1'b1;
    run(v_basic, 0, 0, 0, -1, 0, 28, 0);
    run(v_basic, 0, 0, 0, -1, 0, 0, 81);
    @(negedge CLK);
    sq_valid_out = 1'b1;
    sq_output_val = 16'hDEAD;
    @(negedge CLK);
    sq_valid_out = 1'b0;
    check("idle_spur_lane0", 32'(vec_out[0]), 32'h3C00);
    check("idle_spur_lane3", 32'(vec_out[3]), 0);
    check("idle_spur_busy", 32'(busy), 0);
    run(v_basic, 1, 4, 2, -1, 0, 0, 85);
    run(v_basic, 16, 7, 0, -1, 0, 0, 88);
    run(v_basic, 0, 0, 76, 2, 0, 0, 141);
    repeat (3) @(negedge CLK);
    check("err_sticky", 32'(err), 1);
    run(v_basic, 0, 0, 0, -1, 22, 0, 81);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sqrt_issue_seq.md
# sqrt_issue_seq

Initiator-side sequencer for the fp16 `sqrt` unit in the vector datapath. It snapshots a vector of `LANES` fp16 operands on `start`, then issues them one at a time to a `sqrt` unit over its `ready` / `valid_data_in` / `valid_data_out` handshake. It collects each result into an output vector and pulses `done` when all lanes have returned. A per-lane watchdog substitutes qNaN and flags an error if the responder never answers.

## Interface
Parameters:
- `LANES`, 16: number of fp16 lanes per vector (≥2).
- `TIMEOUT`, 64: maximum cycles spent in WAIT per lane before the watchdog fires (≥2).

Ports:
- `CLK`  in  1  clock, all logic on posedge.
- `nRST`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  begin a vector operation; honoured only in IDLE.
- `vec_in`  in  `LANES`×16 (`fp16_t` array)  operands; sampled only in the `start` cycle.
- `sq_ready`  in  1  responder `ready`.
- `sq_valid_out`  in  1  responder `valid_data_out`.
- `sq_output_val`  in  16 (`fp16_t`)  responder result.
- `sq_input_val`  out  16 (`fp16_t`)  operand to responder, registered.
- `sq_valid_in`  out  1  request pulse, registered, exactly one cycle per lane.
- `vec_out`  out  `LANES`×16  result vector, registered.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky watchdog flag; cleared by the next accepted `start`.

## Operation
- Reset values:
  - state = IDLE.
  - lane index `idx` = 0.
  - watchdog counter = 0.
  - `sq_input_val` = 0, `sq_valid_in` = 0.
  - `vec_out` = all 0.
  - `busy` = 0, `done` = 0, `err` = 0.
- IDLE: if `start`, copy `vec_in` to an internal operand buffer, clear `idx` and `err`, and go to ISSUE. `vec_out` is not cleared.
- ISSUE: if `sq_ready`:
  - register `sq_input_val` = buffer[`idx`] and `sq_valid_in` = 1;
  - clear the watchdog;
  - go to WAIT.
  - Otherwise stay in ISSUE indefinitely (no watchdog in ISSUE).
- WAIT:
  - `sq_valid_in` returns to 0 after its single cycle.
  - Each cycle, if `sq_valid_out`, capture `sq_output_val` into `vec_out[idx]`.
  - Else if the watchdog has reached `TIMEOUT`−1, write 16'h7E00 to `vec_out[idx]` and set `err`.
  - Else increment the watchdog.
  - On capture or timeout: if `idx` == `LANES`−1, go to DONE; otherwise increment `idx` and go to ISSUE.
- DONE: `done` = 1 for this cycle only, then go to IDLE.
- One request outstanding at a time; lanes are issued in ascending index order.
- `sq_valid_out` is ignored in IDLE, ISSUE and DONE. Late responses after a timeout are discarded.
- `start` while `busy` is ignored and does not disturb the operation.
- `sq_input_val` holds its last value when `sq_valid_in` is low.
- `nRST` asserted mid-operation aborts immediately to the reset values; the in-flight response is dropped.

## Timing
- `start` sampled at edge 0 → ISSUE during cycle 1.
- ISSUE with `sq_ready` high at cycle c → `sq_valid_in` high during cycle c+1 (state WAIT).
- With responder latency L, `sq_valid_out` arrives at cycle c+1+L and is captured on that edge → next ISSUE at c+2+L.
- Per lane with `sq_ready` always high: L+2 cycles.
- `done` pulses at cycle 1+`LANES`·(L+2); `busy` falls the cycle after `done`.
- `vec_out[idx]` is updated on the capture edge; the full vector is valid when `done` is high.
- A timeout lane costs 1+`TIMEOUT` cycles from its ISSUE.

## Test plan
- Reset mid-operation: assert `nRST` low during WAIT of lane 5 → all outputs at reset values, state IDLE; a following `start` runs cleanly from lane 0.
- Basic vector: behavioural responder with L=3, `sq_ready` high, `vec_in` lanes 0..2 = 0x3C00, 0x4400, 0x4C00 (rest 0x0000) → `vec_out` = 0x3C00, 0x4000, 0x4400, zeros elsewhere. Exactly 16 `sq_valid_in` pulses, each one cycle; `done` at cycle 1+16·5 = 81.
- Ready backpressure: hold `sq_ready` low for 7 cycles at lane 3 → no `sq_valid_in` during the stall, no `err`; results correct and `done` delayed by exactly 7 cycles.
- Watchdog: responder never answers lane 2 (`TIMEOUT`=64) → `vec_out[2]` = 0x7E00 and `err`=1 after 64 WAIT cycles. Remaining lanes are correct, and a late `sq_valid_out` for lane 2 arriving in ISSUE is ignored. `err` stays set until the next `start`.
- Start while busy: pulse `start` with a different `vec_in` during lane 4 → the original operands complete unchanged, with a single `done`.
- Spurious response: `sq_valid_out` asserted in IDLE and in ISSUE → no change to `vec_out` or `idx`.
